ifetch_unit: RTL and testbench

- Instruction-fetch front end: the initiator side of the instruction-memory read interface.
- Owns the PC, drives the 8-bit word address to the instruction memory and captures the returned 16-bit word the same cycle (memory read is combinational).
- Buffers fetched words in a 2-entry queue feeding decode via valid/ready.
- Redirects early on unconditional jumps, and on late redirects from execute (branch/jr).

---
 rtl/ifetch_unit_pkg.sv | 19 +
 rtl/ifetch_queue.sv | 79 +++++++
 rtl/ifetch_unit.sv | 80 ++++++++
 tb/tb_ifetch_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: widths, jump opcode,
// reset PC and the queued fetch entry.
package ifetch_unit_pkg;

   localparam int AW = 8;
   localparam int DW = 16;
   localparam logic [3:0]    JMP_OP   = 4'b0010;
   localparam logic [AW-1:0] RESET_PC = 8'h00;

   typedef struct packed {
      logic [DW-1:0] instr;
      logic [AW-1:0] pc;
   } fetch_entry_t;

   function automatic logic is_jump(input logic [DW-1:0] iw);
      return (iw[15:12] == JMP_OP);
   endfunction

endpackage

// File: rtl/ifetch_queue.sv
// Two-entry in-order fetch queue; entry 0 is always the head, flush empties it.
module ifetch_queue
   import ifetch_unit_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic         flush_i,
   input  fetch_entry_t entry_i,
   output fetch_entry_t head_o,
   output logic         valid_o,
   output logic         full_o,
   output logic [1:0]   count_o
);

   fetch_entry_t e0_q, e0_d;
   fetch_entry_t e1_q, e1_d;
   logic [1:0]   cnt_q, cnt_d;
   logic         pop_s;
   logic         push_s;

   // next-state for the two slots and the occupancy count
   always_comb begin
      e0_d   = e0_q;
      e1_d   = e1_q;
      cnt_d  = cnt_q;
      pop_s  = pop_i & (cnt_q != 2'd0);
      push_s = push_i & ((cnt_q != 2'd2) | pop_s);
      if (flush_i) begin
         cnt_d = 2'd0;
         e0_d  = '0;
         e1_d  = '0;
      end else begin
         case ({push_s, pop_s})
            2'b10: begin
               if (cnt_q == 2'd0) e0_d = entry_i;
               else               e1_d = entry_i;
               cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
               e0_d  = e1_q;
               cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
               // simultaneous push/pop: head advances, new word takes the freed slot
               if (cnt_q == 2'd1) begin
                  e0_d = entry_i;
               end else begin
                  e0_d = e1_q;
                  e1_d = entry_i;
               end
            end
            default: begin
               cnt_d = cnt_q;
            end
         endcase
      end
   end

   // queue state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e0_q  <= '0;
         e1_q  <= '0;
         cnt_q <= 2'd0;
      end else begin
         e0_q  <= e0_d;
         e1_q  <= e1_d;
         cnt_q <= cnt_d;
      end
   end

   assign head_o  = e0_q;
   assign valid_o = (cnt_q != 2'd0);
   assign full_o  = (cnt_q == 2'd2);
   assign count_o = cnt_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: PC, early jump redirect, late execute redirect,
// fetch counter, and a two-entry queue feeding decode.
module ifetch_unit
   import ifetch_unit_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          run,
   output logic [AW-1:0] imem_addr,
   input  logic [DW-1:0] imem_iw,
   input  logic          redir_valid,
   input  logic [AW-1:0] redir_addr,
   input  logic          id_ready,
   output logic          id_valid,
   output logic [DW-1:0] id_instr,
   output logic [AW-1:0] id_pc,
   output logic [15:0]   fetch_cnt
);

   logic [AW-1:0] pc_q, pc_d;
   logic [15:0]   fcnt_q, fcnt_d;
   logic          pop_s;
   logic          push_s;
   logic          q_valid_s;
   logic          q_full_s;
   logic [1:0]    q_count_s;
   fetch_entry_t  q_head_s;
   fetch_entry_t  q_entry_s;

   assign pop_s     = id_ready & (q_count_s != 2'd0) & ~redir_valid;
   assign push_s    = run & ~redir_valid & (~q_full_s | pop_s);
   assign q_entry_s = '{instr: imem_iw, pc: pc_q};

   // next PC and fetch counter; execute redirect outranks everything
   always_comb begin
      pc_d   = pc_q;
      fcnt_d = fcnt_q;
      if (redir_valid) begin
         pc_d = redir_addr;
      end else if (push_s) begin
         if (is_jump(imem_iw)) pc_d = imem_iw[AW-1:0];
         else                  pc_d = pc_q + AW'(1);
         if (fcnt_q != 16'hFFFF) fcnt_d = fcnt_q + 16'd1;
         else                    fcnt_d = fcnt_q;
      end else begin
         pc_d = pc_q;
      end
   end

   // PC and counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q   <= RESET_PC;
         fcnt_q <= 16'd0;
      end else begin
         pc_q   <= pc_d;
         fcnt_q <= fcnt_d;
      end
   end

   ifetch_queue u_queue (
      .clk     (clk),
      .rst     (reset),
      .push_i  (push_s),
      .pop_i   (pop_s),
      .flush_i (redir_valid),
      .entry_i (q_entry_s),
      .head_o  (q_head_s),
      .valid_o (q_valid_s),
      .full_o  (q_full_s),
      .count_o (q_count_s)
   );

   assign imem_addr = pc_q;
   assign id_valid  = q_valid_s;
   assign id_instr  = q_head_s.instr;
   assign id_pc     = q_head_s.pc;
   assign fetch_cnt = fcnt_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: expected deliveries are queued by the
// stimulus and checked by an independent monitor on each accepted head.
module tb_ifetch_unit;
   import ifetch_unit_pkg::*;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          run = 1'b0;
   logic [AW-1:0] imem_addr;
   logic [DW-1:0] imem_iw;
   logic          redir_valid = 1'b0;
   logic [AW-1:0] redir_addr = 8'h00;
   logic          id_ready = 1'b0;
   logic          id_valid;
   logic [DW-1:0] id_instr;
   logic [AW-1:0] id_pc;
   logic [15:0]   fetch_cnt;

   logic [DW-1:0] mem [0:255];
   fetch_entry_t  sb [$];
   int            total = 0;
   int            bad = 0;

   ifetch_unit dut (
      .clk         (clk),
      .reset       (reset),
      .run         (run),
      .imem_addr   (imem_addr),
      .imem_iw     (imem_iw),
      .redir_valid (redir_valid),
      .redir_addr  (redir_addr),
      .id_ready    (id_ready),
      .id_valid    (id_valid),
      .id_instr    (id_instr),
      .id_pc       (id_pc),
      .fetch_cnt   (fetch_cnt)
   );

   always #5 clk = ~clk;

   assign imem_iw = mem[imem_addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_pc(input logic [7:0] pc);
      fetch_entry_t e;
      e.pc    = pc;
      e.instr = mem[pc];
      sb.push_back(e);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      redir_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      sb.delete();
   endtask

   // monitor: every head accepted by decode must match the oldest expectation
   always @(negedge clk) begin
      if (!reset && id_valid && id_ready && sb.size() > 0) begin
         fetch_entry_t e;
         e = sb.pop_front();
         total++;
         if ({id_instr, id_pc} !== {e.instr, e.pc}) begin
            bad++;
            $display("FAIL deliver actual=%h/%h expected=%h/%h", id_instr, id_pc, e.instr, e.pc);
         end
      end
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);

      // in-order streaming after reset
      run = 1'b1; id_ready = 1'b1;
      do_reset();
      chk("rst_addr", 32'(imem_addr), 32'h0);
      chk("rst_valid", 32'(id_valid), 32'h0);
      chk("rst_cnt", 32'(fetch_cnt), 32'h0);
      chk("rst_instr", 32'(id_instr), 32'h0);
      chk("rst_pc", 32'(id_pc), 32'h0);
      for (int k = 0; k < 4; k++) expect_pc(8'(k));
      for (int k = 1; k <= 4; k++) begin
         step();
         chk("stream_valid", 32'(id_valid), 32'h1);
         chk("stream_pc", 32'(id_pc), 32'(k - 1));
      end
      chk("stream_cnt", 32'(fetch_cnt), 32'd4);
      step();
      chk("stream_drain", 32'(sb.size()), 32'd0);

      // backpressure fills the queue and stalls the PC
      id_ready = 1'b0;
      do_reset();
      repeat (3) step();
      chk("bp_valid", 32'(id_valid), 32'h1);
      chk("bp_pc", 32'(id_pc), 32'h0);
      chk("bp_addr", 32'(imem_addr), 32'h2);
      chk("bp_cnt", 32'(fetch_cnt), 32'd2);
      id_ready = 1'b1;
      for (int k = 0; k < 3; k++) expect_pc(8'(k));
      step();
      chk("bp_pc1", 32'(id_pc), 32'h1);
      step();
      chk("bp_pc2", 32'(id_pc), 32'h2);
      step();
      chk("bp_drain", 32'(sb.size()), 32'd0);

      // early jump at address 3 back to 0
      mem[3] = 16'h2000;
      id_ready = 1'b1;
      do_reset();
      for (int k = 0; k < 4; k++) expect_pc(8'(k));
      expect_pc(8'h00);
      expect_pc(8'h01);
      repeat (3) step();
      chk("jmp_addr3", 32'(imem_addr), 32'h3);
      step();
      chk("jmp_addr0", 32'(imem_addr), 32'h0);
      repeat (3) step();
      chk("jmp_drain", 32'(sb.size()), 32'd0);
      mem[3] = 16'h1003;

      // execute redirect flushes a full queue
      id_ready = 1'b0;
      do_reset();
      repeat (3) step();
      redir_valid = 1'b1; redir_addr = 8'h40;
      step();
      redir_valid = 1'b0;
      chk("redir_valid0", 32'(id_valid), 32'h0);
      chk("redir_addr", 32'(imem_addr), 32'h40);
      expect_pc(8'h40);
      expect_pc(8'h41);
      id_ready = 1'b1;
      step();
      chk("redir_valid1", 32'(id_valid), 32'h1);
      chk("redir_pc", 32'(id_pc), 32'h40);
      step();
      chk("redir_pc41", 32'(id_pc), 32'h41);
      step();
      chk("redir_drain", 32'(sb.size()), 32'd0);

      // PC wraps from FF to 00
      id_ready = 1'b1;
      do_reset();
      redir_valid = 1'b1; redir_addr = 8'hFE;
      step();
      redir_valid = 1'b0;
      expect_pc(8'hFE); expect_pc(8'hFF); expect_pc(8'h00); expect_pc(8'h01);
      repeat (5) step();
      chk("wrap_drain", 32'(sb.size()), 32'd0);

      // asynchronous reset between edges with a full queue
      id_ready = 1'b0;
      do_reset();
      repeat (3) step();
      chk("areset_pre_cnt", 32'(fetch_cnt), 32'd2);
      #2 reset = 1'b1;
      #1;
      chk("areset_valid", 32'(id_valid), 32'h0);
      chk("areset_addr", 32'(imem_addr), 32'h0);
      chk("areset_cnt", 32'(fetch_cnt), 32'h0);
      chk("areset_pc", 32'(id_pc), 32'h0);
      reset = 1'b0;
      id_ready = 1'b1;
      for (int k = 0; k < 3; k++) expect_pc(8'(k));
      repeat (4) step();
      chk("areset_drain", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
